// File: rtl/a_line_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : aline_pkg
// Brief    : Shared sizes, read-FSM states and header layout for the A-line
//            buffer. The HDR state exists only when ALINE_HDR_EN is defined.
// Revision : 1.0
// ============================================================================
package aline_pkg;

  localparam int NSAMPLES_DEF = 1170;
  localparam int AW           = 11;
  localparam int DW           = 14;
  localparam int OW           = 16;

  typedef enum logic [2:0] {
    RD_IDLE    = 3'd0,
`ifdef ALINE_HDR_EN
    RD_HDR     = 3'd1,
`endif
    RD_FETCH   = 3'd2,
    RD_STREAM  = 3'd3,
    RD_RELEASE = 3'd4
  } rd_state_t;

  typedef struct packed {
    logic [OW-1:0] line_num;
  } aline_hdr_t;

endpackage
`default_nettype wire

// File: rtl/a_line_buffer_if.sv
`default_nettype none
// ============================================================================
// Interface : a_line_buffer_if
// Brief     : Valid/ready output stream carrying A-line words with sop/eop.
// Revision  : 1.0
// ============================================================================
interface a_line_buffer_if;
  import aline_pkg::*;

  logic [OW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_sop;
  logic          dout_eop;

  modport master (output dout, dout_valid, dout_sop, dout_eop, input dout_ready);
  modport slave  (input dout, dout_valid, dout_sop, dout_eop, output dout_ready);

endinterface
`default_nettype wire

// File: rtl/a_line_buffer_dpram.sv
`default_nettype none
// ============================================================================
// Module   : alb_dpram
// Brief    : Simple dual-port RAM holding both banks; registered read port.
// Revision : 1.0
// ============================================================================
module alb_dpram
  import aline_pkg::*;
(
  input  wire logic          clk,
  input  wire logic          i_wr_en,
  input  wire logic [AW:0]   i_wr_addr,
  input  wire logic [DW-1:0] i_wr_data,
  input  wire logic          i_rd_en,
  input  wire logic [AW:0]   i_rd_addr,
  output logic      [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem [2**(AW+1)];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Read register only advances on request so a stalled word stays put.
  always_ff @(posedge clk) begin
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/a_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : a_line_buffer
// Brief    : Ping-pong A-line capture buffer streaming full banks to the host.
//            Define ALINE_HDR_EN to prefix each line with a line-number header.
// Revision : 1.0
// ============================================================================
module a_line_buffer
  import aline_pkg::*;
#(
  parameter int NSAMPLES = NSAMPLES_DEF
) (
  input  wire logic          clk_system,
  input  wire logic          global_reset,
  input  wire logic          acq_busy,
  input  wire logic          sample_valid,
  input  wire logic [DW-1:0] a_line_in,
  a_line_buffer_if.master    dout_if,
  output logic      [15:0]   line_count,
  output logic      [7:0]    drop_count,
  output logic      [7:0]    short_count
);

  localparam logic [AW-1:0] c_LAST = AW'(NSAMPLES - 1);

  logic          r_busy_d, r_wr_en, r_line_done, r_wbank, r_last_done, r_rbank;
  logic [AW-1:0] r_wcnt, r_raddr;
  logic [1:0]    r_full;
  rd_state_t     r_state, w_state_nxt;

  logic          w_rise, w_fall, w_wr, w_done, w_release, w_accept, w_rd_en, w_pick;
  logic [1:0]    w_rel_mask, w_done_mask, w_free;
  logic [AW-1:0] w_rd_addr;
  logic [DW-1:0] w_rd_data;

  assign w_rise      = acq_busy & ~r_busy_d;
  assign w_fall      = ~acq_busy & r_busy_d;
  assign w_wr        = sample_valid & acq_busy & r_wr_en & ~r_line_done;
  assign w_done      = w_wr & (r_wcnt == c_LAST);
  assign w_release   = (r_state == RD_RELEASE);
  assign w_rel_mask  = w_release ? (2'b01 << r_rbank) : 2'b00;
  assign w_done_mask = w_done ? (2'b01 << r_wbank) : 2'b00;
  // A bank being released this cycle already counts as free for the writer.
  assign w_free      = ~r_full | w_rel_mask;
  assign w_accept    = dout_if.dout_valid & dout_if.dout_ready;
  assign w_pick      = (r_full == 2'b11) ? ~r_last_done : r_full[1];

  always_ff @(posedge clk_system or negedge global_reset) begin
    if (!global_reset) begin
      r_busy_d    <= 1'b0;
      r_wr_en     <= 1'b1;
      r_line_done <= 1'b0;
      r_wbank     <= 1'b0;
      r_last_done <= 1'b0;
      r_wcnt      <= '0;
      r_full      <= 2'b00;
      line_count  <= '0;
      drop_count  <= '0;
      short_count <= '0;
    end else begin
      r_busy_d <= acq_busy;
      r_full   <= (r_full & ~w_rel_mask) | w_done_mask;
      if (w_rise) r_line_done <= 1'b0;
      if (w_done) begin
        line_count  <= line_count + 16'd1;
        r_last_done <= r_wbank;
        r_line_done <= 1'b1;
        r_wcnt      <= '0;
        if (w_free[~r_wbank]) r_wbank <= ~r_wbank;
        else                  r_wr_en <= 1'b0;
      end else if (w_wr) begin
        r_wcnt <= r_wcnt + AW'(1);
      end else if (w_fall) begin
        if (r_wcnt != '0) begin
          r_wcnt <= '0;
          if (short_count != 8'hFF) short_count <= short_count + 8'd1;
        end
      end else if (w_rise && !r_wr_en) begin
        if (|w_free) begin
          r_wr_en <= 1'b1;
          r_wbank <= w_free[r_wbank] ? r_wbank : ~r_wbank;
        end else if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 8'd1;
        end
      end
    end
  end

`ifdef ALINE_HDR_EN
  aline_hdr_t r_hdr [2];

  always_ff @(posedge clk_system or negedge global_reset) begin
    if (!global_reset) begin
      r_hdr[0] <= '0;
      r_hdr[1] <= '0;
    end else if (w_done) begin
      r_hdr[r_wbank].line_num <= line_count + 16'd1;
    end
  end
`endif

  alb_dpram u_ram (
    .clk       (clk_system),
    .i_wr_en   (w_wr),
    .i_wr_addr ({r_wbank, r_wcnt}),
    .i_wr_data (a_line_in),
    .i_rd_en   (w_rd_en),
    .i_rd_addr ({r_rbank, w_rd_addr}),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk_system or negedge global_reset) begin
    if (!global_reset) begin
      r_state <= RD_IDLE;
      r_rbank <= 1'b0;
      r_raddr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == RD_IDLE) r_rbank <= w_pick;
      if (r_state == RD_FETCH) r_raddr <= '0;
      else if (r_state == RD_STREAM && w_accept && r_raddr != c_LAST)
        r_raddr <= r_raddr + AW'(1);
    end
  end

  // Prefetch address r_raddr+1 on each acceptance keeps words back-to-back.
  always_comb begin
    w_state_nxt        = r_state;
    w_rd_en            = 1'b0;
    w_rd_addr          = r_raddr + AW'(1);
    dout_if.dout_valid = 1'b0;
    dout_if.dout       = '0;
    dout_if.dout_sop   = 1'b0;
    dout_if.dout_eop   = 1'b0;
    case (r_state)
      RD_IDLE: begin
`ifdef ALINE_HDR_EN
        if (|r_full) w_state_nxt = RD_HDR;
`else
        if (|r_full) w_state_nxt = RD_FETCH;
`endif
      end
`ifdef ALINE_HDR_EN
      RD_HDR: begin
        dout_if.dout_valid = 1'b1;
        dout_if.dout_sop   = 1'b1;
        dout_if.dout       = r_hdr[r_rbank];
        if (dout_if.dout_ready) w_state_nxt = RD_FETCH;
      end
`endif
      RD_FETCH: begin
        w_rd_en     = 1'b1;
        w_rd_addr   = '0;
        w_state_nxt = RD_STREAM;
      end
      RD_STREAM: begin
        dout_if.dout_valid = 1'b1;
        dout_if.dout       = {{(OW-DW){1'b0}}, w_rd_data};
        dout_if.dout_eop   = (r_raddr == c_LAST);
`ifndef ALINE_HDR_EN
        dout_if.dout_sop   = (r_raddr == '0);
`endif
        if (dout_if.dout_ready) begin
          if (r_raddr == c_LAST) w_state_nxt = RD_RELEASE;
          else                   w_rd_en     = 1'b1;
        end
      end
      RD_RELEASE: w_state_nxt = RD_IDLE;
      default:    w_state_nxt = RD_IDLE;
    endcase
  end

endmodule
`default_nettype wire
